// File: rtl/wr_sel_decoder_q.sv
// wr_sel_decoder_q
// Registered write-select decoder for a register file. An ADDR_W-bit write
// address is turned into a one-hot write-enable vector of 2**ADDR_W bits,
// buffered in a two-entry FIFO behind a valid/ready handshake. It supports
// broadcast (all registers enabled), no-write tokens, a hard-wired zero register
// that is never enabled, and a saturating count of writes lost to that register.
// Every output comes straight from a flop. There is no combinational path from
// the request side to the outputs.

module wr_sel_decoder_q #(
  parameter int ADDR_W   = 5,
  parameter int HAS_ZERO = 1,
  parameter int ZERO_IDX = 31,   // must be < 2**ADDR_W
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic                   in_en,
  input  logic                   in_bcast,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2**ADDR_W-1:0]   out_y,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int NUM_OUT = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  // Queue occupancy. The head entry always drives the outputs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Builds the write-enable vector for one request. The zero register is masked last,
  // so broadcast cannot enable it either.
  function automatic logic [NUM_OUT-1:0] f_decode(
    input logic [ADDR_W-1:0] addr,
    input logic              en,
    input logic              bcast
  );
    logic [NUM_OUT-1:0] v;
    v = {NUM_OUT{1'b0}};
    if (!en) begin
      v = {NUM_OUT{1'b0}};
    end else if (bcast) begin
      v = {NUM_OUT{1'b1}};
    end else begin
      v[addr] = 1'b1;
    end
    if (HAS_ZERO != 0) begin
      v[ZERO_A] = 1'b0;
    end
    return v;
  endfunction

  // True for a real single-register write that the zero register swallows.
  function automatic logic f_is_drop(
    input logic [ADDR_W-1:0] addr,
    input logic              en,
    input logic              bcast
  );
    return (HAS_ZERO != 0) && en && !bcast && (addr == ZERO_A);
  endfunction

  // Increments and sticks at all-ones, never wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == {CNT_W{1'b1}}) begin
      r = c;
    end else begin
      r = c + CNT_W'(1'b1);
    end
    return r;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [NUM_OUT-1:0]  r_head_y;
  logic [ADDR_W-1:0]   r_head_addr;
  logic [NUM_OUT-1:0]  r_tail_y;
  logic [ADDR_W-1:0]   r_tail_addr;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic                w_accept;
  logic                w_pop;
  logic [NUM_OUT-1:0]  w_entry_y;
  logic [NUM_OUT-1:0]  w_head_y_nxt;
  logic [ADDR_W-1:0]   w_head_addr_nxt;
  logic [NUM_OUT-1:0]  w_tail_y_nxt;
  logic [ADDR_W-1:0]   w_tail_addr_nxt;

  assign w_accept  = in_valid & r_in_ready;
  assign w_pop     = r_out_valid & out_ready;
  assign w_entry_y = f_decode(in_addr, in_en, in_bcast);

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy from the accept/pop pair. Accept in TWO cannot occur because
  // in_ready is low there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_pop) begin
          w_state_nxt = ST_TWO;
        end else if (!w_accept && w_pop) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Head/tail slot updates. Any slot that becomes empty is zeroed, so idle outputs
  // read as all zeros.
  always_comb begin
    w_head_y_nxt    = r_head_y;
    w_head_addr_nxt = r_head_addr;
    w_tail_y_nxt    = r_tail_y;
    w_tail_addr_nxt = r_tail_addr;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_head_y_nxt    = w_entry_y;
          w_head_addr_nxt = in_addr;
        end else begin
          w_head_y_nxt    = {NUM_OUT{1'b0}};
          w_head_addr_nxt = {ADDR_W{1'b0}};
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          // The old head leaves, and the new request goes straight to the head slot.
          w_head_y_nxt    = w_entry_y;
          w_head_addr_nxt = in_addr;
        end else if (w_accept) begin
          w_tail_y_nxt    = w_entry_y;
          w_tail_addr_nxt = in_addr;
        end else if (w_pop) begin
          w_head_y_nxt    = {NUM_OUT{1'b0}};
          w_head_addr_nxt = {ADDR_W{1'b0}};
        end else begin
          w_head_y_nxt    = r_head_y;
          w_head_addr_nxt = r_head_addr;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_head_y_nxt    = r_tail_y;
          w_head_addr_nxt = r_tail_addr;
          w_tail_y_nxt    = {NUM_OUT{1'b0}};
          w_tail_addr_nxt = {ADDR_W{1'b0}};
        end else begin
          w_head_y_nxt    = r_head_y;
          w_head_addr_nxt = r_head_addr;
        end
      end
      default: begin
        w_head_y_nxt    = {NUM_OUT{1'b0}};
        w_head_addr_nxt = {ADDR_W{1'b0}};
        w_tail_y_nxt    = {NUM_OUT{1'b0}};
        w_tail_addr_nxt = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Queue storage and registered handshake flags. Both flags are taken from the
  // next occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head_y    <= {NUM_OUT{1'b0}};
      r_head_addr <= {ADDR_W{1'b0}};
      r_tail_y    <= {NUM_OUT{1'b0}};
      r_tail_addr <= {ADDR_W{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_head_y    <= w_head_y_nxt;
      r_head_addr <= w_head_addr_nxt;
      r_tail_y    <= w_tail_y_nxt;
      r_tail_addr <= w_tail_addr_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_TWO);
    end
  end

  // Saturating count of accepted writes that the zero register swallowed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_drop_cnt <= {CNT_W{1'b0}};
    end else if (w_accept && f_is_drop(in_addr, in_en, in_bcast)) begin
      r_drop_cnt <= f_sat_inc(r_drop_cnt);
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_head_y;
  assign out_addr  = r_head_addr;
  assign drop_cnt  = r_drop_cnt;

  wr_sel_decoder_q_chk #(
    .ADDR_W   (ADDR_W),
    .HAS_ZERO (HAS_ZERO),
    .ZERO_IDX (ZERO_IDX)
  ) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .out_valid (r_out_valid),
    .out_ready (out_ready),
    .out_y     (r_head_y),
    .out_addr  (r_head_addr)
  );

endmodule

// Output-side invariants for wr_sel_decoder_q.
module wr_sel_decoder_q_chk #(
  parameter int ADDR_W   = 5,
  parameter int HAS_ZERO = 1,
  parameter int ZERO_IDX = 31
) (
  input logic                 clk,
  input logic                 reset_n,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic [2**ADDR_W-1:0] out_y,
  input logic [ADDR_W-1:0]    out_addr
);

  localparam int NUM_OUT = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  // An idle output carries no enables and no address.
  a_idle_clear: assert property (@(posedge clk) disable iff (!reset_n)
    !out_valid |-> (out_y == {NUM_OUT{1'b0}} && out_addr == {ADDR_W{1'b0}}));

  // A stalled head entry stays unchanged until the consumer takes it.
  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready) |=> ($stable(out_y) && $stable(out_addr)));

  generate
    if (HAS_ZERO != 0) begin : g_zero
      // The zero register is never write-enabled.
      a_zero_off: assert property (@(posedge clk) disable iff (!reset_n)
        !out_y[ZERO_A]);
    end
  endgenerate

endmodule

// File: tb/tb_wr_sel_decoder_q.sv
// Testbench for wr_sel_decoder_q. It drives three builds with identical stimulus:
// the default build, a build without a zero register, and a build with a 2-bit
// drop counter. A queue-based reference model predicts the expected outputs of
// all three builds on every cycle.

module tb_wr_sel_decoder_q;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_en, in_bcast, out_ready;
  logic [4:0]  in_addr;

  logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
  logic [31:0] y_a, y_b, y_c;
  logic [4:0]  addr_a, addr_b, addr_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  always #5 clk = ~clk;

  wr_sel_decoder_q #(.ADDR_W(5), .HAS_ZERO(1), .ZERO_IDX(31), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_addr(in_addr), .in_en(in_en), .in_bcast(in_bcast), .out_valid(vld_a),
    .out_ready(out_ready), .out_y(y_a), .out_addr(addr_a), .drop_cnt(cnt_a));

  wr_sel_decoder_q #(.ADDR_W(5), .HAS_ZERO(0), .ZERO_IDX(31), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_addr(in_addr), .in_en(in_en), .in_bcast(in_bcast), .out_valid(vld_b),
    .out_ready(out_ready), .out_y(y_b), .out_addr(addr_b), .drop_cnt(cnt_b));

  wr_sel_decoder_q #(.ADDR_W(5), .HAS_ZERO(1), .ZERO_IDX(31), .CNT_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_c),
    .in_addr(in_addr), .in_en(in_en), .in_bcast(in_bcast), .out_valid(vld_c),
    .out_ready(out_ready), .out_y(y_c), .out_addr(addr_c), .drop_cnt(cnt_c));

  typedef struct packed {
    logic [4:0] addr;
    logic       en;
    logic       bcast;
  } req_t;

  req_t q[$];
  int   m_cnt_a;
  int   m_cnt_c;
  bit   last_acc;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Enables a request should produce, derived from the decoding rules.
  function automatic logic [31:0] exp_y(input req_t r, input bit has_zero);
    logic [31:0] y;
    if (!r.en)         y = 32'h0;
    else if (r.bcast)  y = 32'hFFFF_FFFF;
    else               y = 32'h1 << r.addr;
    if (has_zero)      y = y & ~(32'h1 << 31);
    return y;
  endfunction

  task automatic check_all();
    req_t        h;
    logic [31:0] ey_a, ey_b;
    logic [4:0]  ea;
    if (q.size() > 0) begin
      h = q[0]; ey_a = exp_y(h, 1'b1); ey_b = exp_y(h, 1'b0); ea = h.addr;
    end else begin
      ey_a = 32'h0; ey_b = 32'h0; ea = 5'd0;
    end
    chk("ready_a", rdy_a, q.size() < 2);
    chk("valid_a", vld_a, q.size() > 0);
    chk("y_a",     y_a,   ey_a);
    chk("addr_a",  addr_a, ea);
    chk("cnt_a",   cnt_a, m_cnt_a);
    chk("ready_b", rdy_b, q.size() < 2);
    chk("valid_b", vld_b, q.size() > 0);
    chk("y_b",     y_b,   ey_b);
    chk("addr_b",  addr_b, ea);
    chk("cnt_b",   cnt_b, 64'd0);
    chk("valid_c", vld_c, q.size() > 0);
    chk("y_c",     y_c,   ey_a);
    chk("cnt_c",   cnt_c, m_cnt_c);
  endtask

  // One clock: the model applies this edge's accept/pop, and then the outputs are checked.
  task automatic step();
    bit   acc, pop;
    req_t r;
    acc     = in_valid && (q.size() < 2);
    pop     = (q.size() > 0) && out_ready;
    r.addr  = in_addr;
    r.en    = in_en;
    r.bcast = in_bcast;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_cnt_a  = 0;
      m_cnt_c  = 0;
      last_acc = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(r);
        if (r.en && !r.bcast && r.addr == 5'd31) begin
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_c < 3)     m_cnt_c++;
        end
      end
      last_acc = acc;
    end
    #1;
    check_all();
  endtask

  task automatic req(input logic [4:0] a, input logic en, input logic bc);
    in_valid = 1'b1; in_addr = a; in_en = en; in_bcast = bc;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_addr = 5'd0; in_en = 1'b0; in_bcast = 1'b0;
  endtask

  logic [15:0] cnt_before;

  initial begin
    m_cnt_a = 0; m_cnt_c = 0; last_acc = 1'b0;
    reset_n = 1'b0; out_ready = 1'b0;
    idle();
    step(); step();
    reset_n = 1'b1;

    // Reset while two entries are queued.
    req(5'd3, 1'b1, 1'b0); step();
    req(5'd7, 1'b1, 1'b0); step();
    idle();
    chk("pre_rst_ready", rdy_a, 1'b0);
    reset_n = 1'b0; step(); step();
    reset_n = 1'b1;
    chk("rst_valid", vld_a, 1'b0);
    chk("rst_y",     y_a,   32'h0);
    chk("rst_cnt",   cnt_a, 16'd0);
    chk("rst_ready", rdy_a, 1'b1);
    step();
    chk("rst_lost",  vld_a, 1'b0);

    // Back-to-back sweep over every address.
    out_ready = 1'b1;
    for (int a = 0; a < 32; a++) begin
      req(5'(a), 1'b1, 1'b0); step();
      if (a == 31) chk("sweep_y31", y_a, 32'h0);
      else         chk("sweep_y",   y_a, 32'h1 << a);
    end
    idle(); step();
    chk("sweep_drop", cnt_a, 16'd1);

    // Backpressure and FIFO order.
    out_ready = 1'b0;
    req(5'd3, 1'b1, 1'b0); step();
    req(5'd7, 1'b1, 1'b0); step();
    chk("bp_ready", rdy_a, 1'b0);
    req(5'd9, 1'b1, 1'b0); step(); step();
    chk("bp_hold", y_a, 32'h0000_0008);
    out_ready = 1'b1; step();
    chk("bp_pop2", y_a, 32'h0000_0080);
    step();
    chk("bp_pop3", y_a, 32'h0000_0200);
    idle(); step();
    chk("bp_empty", vld_a, 1'b0);

    // Accept and pop on the same edge while one entry is queued.
    out_ready = 1'b0;
    req(5'd5, 1'b1, 1'b0); step();
    out_ready = 1'b1;
    req(5'd6, 1'b1, 1'b0); step();
    idle();
    chk("ap_y",     y_a,    32'h0000_0040);
    chk("ap_addr",  addr_a, 5'd6);
    chk("ap_ready", rdy_a,  1'b1);
    step();

    // Broadcast and no-write tokens.
    cnt_before = cnt_a;
    req(5'd31, 1'b1, 1'b1); step();
    chk("bc_y_a", y_a, 32'h7FFF_FFFF);
    chk("bc_y_b", y_b, 32'hFFFF_FFFF);
    chk("bc_cnt", cnt_a, cnt_before);
    req(5'd4, 1'b0, 1'b1); step();
    chk("nw_y",     y_a,    32'h0);
    chk("nw_valid", vld_a,  1'b1);
    chk("nw_addr",  addr_a, 5'd4);
    idle(); step();

    // Saturation of the 2-bit drop counter.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req(5'd31, 1'b1, 1'b0); step();
      chk("sat_cnt", cnt_c, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    idle(); step();

    // Randomized traffic. A request is held until it is accepted.
    for (int i = 0; i < 2000; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_addr  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        in_en    = ($urandom_range(0, 7) != 0);
        in_bcast = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    idle(); reset_n = 1'b1; out_ready = 1'b1;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wr_sel_decoder_q.md
Name: wr_sel_decoder_q

Overview:
- Parametrised, registered successor to the register file's fixed 2-to-4 write-select decoder.
- Decodes an ADDR_W-bit write address into a 2**ADDR_W one-hot write-enable vector, as in the 5-to-32 select for the ARM register file.
- Adds a valid/ready handshake, a 2-entry output queue, broadcast mode, hard-wired zero-register suppression and a saturating dropped-write counter.
- Sits between the datapath writeback stage and the register array's per-register write enables.

Parameters:
ADDR_W, 5, address width; NUM_OUT = 2**ADDR_W outputs (derived localparam, not overridable)
HAS_ZERO, 1, 1 = entry ZERO_IDX is the hard-wired zero register and is never write-enabled
ZERO_IDX, 31, index of the zero register; must be < NUM_OUT
CNT_W, 16, width of drop_cnt

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  in  1  request present
in_ready  out  1  block can accept request this cycle
in_addr  in  ADDR_W  write register index
in_en  in  1  write enable for request; 0 = no-write token
in_bcast  in  1  1 = enable all registers (overrides in_addr)
out_valid  out  1  head of queue valid
out_ready  in  1  consumer takes head this cycle
out_y  out  NUM_OUT  decoded write-enable vector of head entry
out_addr  out  ADDR_W  in_addr of head entry, passed through
drop_cnt  out  CNT_W  count of accepted writes suppressed by zero register

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - queue emptied; out_valid=0, out_y=0, out_addr=0, drop_cnt=0, in_ready=1 from the next cycle.
  - Reset overrides any simultaneous accept or pop.
- Handshake:
  - Accept when in_valid & in_ready at an edge.
  - Pop when out_valid & out_ready at an edge.
  - in_valid/in_addr/in_en/in_bcast may change only when not accepted; no combinational in->out path.
- Queue states are EMPTY, ONE and TWO:
  - in_ready = (state != TWO), registered.
  - Accept only: EMPTY->ONE, ONE->TWO.
  - Pop only: TWO->ONE, ONE->EMPTY.
  - Accept+pop in ONE: stays ONE, and the new entry becomes head on the next cycle.
  - Accept+pop in TWO: impossible, because in_ready=0.
  - Accept in EMPTY with out_ready=1: entry becomes head after the edge and is not popped in the same cycle.
- Latency: entry accepted at edge k appears on out_* immediately after edge k when the queue was EMPTY. Minimum latency is one cycle.
- Ordering is strict FIFO. Output ports reflect the head only and are registered; they hold stable while out_valid & !out_ready.
- out_y is computed at accept time and stored:
  - in_en=0: all zeros, regardless of in_bcast. Still queued and still popped.
  - in_en=1, in_bcast=0: bit in_addr set, all others 0.
  - in_en=1, in_bcast=1: all bits set.
  - HAS_ZERO=1: bit ZERO_IDX forced 0 in every case.
- out_valid=0 implies out_y=0 and out_addr=0. Both are cleared on the pop that empties the queue.
- drop_cnt increments by 1 on accept when HAS_ZERO=1, in_en=1, in_bcast=0 and in_addr==ZERO_IDX.
  - Saturates at all-ones with no wrap.
  - Broadcast and no-write tokens never count.
- HAS_ZERO=0: no bit forced; drop_cnt stays 0.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles mid-traffic with 2 entries queued -> next cycle out_valid=0, out_y=0, drop_cnt=0, in_ready=1; queued entries lost.
- Sweep: out_ready=1, accept addr 0..31 with in_en=1 back-to-back.
  - out_y = 1<<addr one cycle later for addr 0..30.
  - addr 31 gives out_y=0 and drop_cnt=1.
- Backpressure: out_ready=0; accept addr 3, then 7.
  - in_ready=0 after the second accept.
  - A third request (addr 9) is held off.
  - Raise out_ready -> pops give out_y=0x00000008 then 0x00000080, then addr 9 gives 0x00000200; FIFO order preserved.
- Simultaneous accept and pop in ONE: queue holds addr 5, then accept addr 6 with out_ready=1 -> state stays ONE, next head out_y=0x00000040, out_addr=6.
- Modes:
  - in_bcast=1, in_en=1 -> out_y=0x7FFFFFFF, drop_cnt unchanged.
  - in_en=0 with addr 4 -> out_y=0, out_valid=1, out_addr=4.
  - HAS_ZERO=0 build, bcast -> out_y=0xFFFFFFFF.
- Saturation with CNT_W=2: 5 accepted writes to addr 31 -> drop_cnt reads 1, 2, 3, 3, 3.
